// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the cacheline adaptor.
//   cla_state_t     - adaptor FSM states (IDLE, RD_BURST, WR_BURST, DONE)
//   CLA_BEATS       - memory beats per cacheline
//   CLA_OFFSET_BITS - byte-offset bits inside one 32-byte cacheline
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } cla_state_t;

  localparam int CLA_BEATS       = 4;
  localparam int CLA_OFFSET_BITS = 5;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: bundles the cache-side line port and the memory-side
// burst port of the cacheline adaptor.
//   cache side : line_i, address_i, read_i, write_i -> adaptor; line_o, resp_o <- adaptor
//   memory side: burst_i, resp_i -> adaptor; burst_o, address_o, read_o, write_o <- adaptor
// Modports:
//   slave  - the adaptor's view (responder to the cache, master to memory)
//   master - the environment's view (cache plus memory model)
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);

  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts whole-line cache read/write requests into
// 4-beat, 64-bit memory bursts with a per-beat resp_i handshake.
// Ports:
//   clk - single clock, all logic on posedge
//   rst - synchronous active-low reset
//   bus - cacheline_adaptor_if.slave (cache line port + memory burst port)
// Configuration macro:
//   CACHELINE_ADAPTOR_ALIGN_EN - when defined, address_o has its line-offset
//   bits [4:0] cleared so every burst starts on the line boundary.
module cacheline_adaptor
  import cla_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input logic               clk,
  input logic               rst,
  cacheline_adaptor_if.slave bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_RD_BURST = RD_BURST;
  localparam logic [1:0] S_WR_BURST = WR_BURST;
  localparam logic [1:0] S_DONE     = DONE;
  localparam logic [1:0] LAST_BEAT  = 2'(CLA_BEATS - 1);

  logic [1:0]        state_r;
  logic [1:0]        cnt_r;
  logic [LINE_W-1:0] buf_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_out_s;
  logic              rd_s;
  logic              wr_s;

  // FSM, beat counter, line buffer and address register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 2'd0;
      buf_r   <= '0;
      addr_r  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // write has priority; a concurrently held read is picked up on
          // the next pass through IDLE
          if (bus.write_i) begin
            buf_r   <= bus.line_i;
            addr_r  <= bus.address_i;
            cnt_r   <= 2'd0;
            state_r <= S_WR_BURST;
          end else if (bus.read_i) begin
            addr_r  <= bus.address_i;
            cnt_r   <= 2'd0;
            state_r <= S_RD_BURST;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RD_BURST: begin
          if (bus.resp_i) begin
            buf_r[cnt_r*BURST_W +: BURST_W] <= bus.burst_i;
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == LAST_BEAT) begin
              state_r <= S_DONE;
            end else begin
              state_r <= S_RD_BURST;
            end
          end else begin
            state_r <= S_RD_BURST;
          end
        end
        S_WR_BURST: begin
          if (bus.resp_i) begin
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == LAST_BEAT) begin
              state_r <= S_DONE;
            end else begin
              state_r <= S_WR_BURST;
            end
          end else begin
            state_r <= S_WR_BURST;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_s = (state_r == S_RD_BURST);
  assign wr_s = (state_r == S_WR_BURST);

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  assign addr_out_s = {addr_r[ADDR_W-1:CLA_OFFSET_BITS], {CLA_OFFSET_BITS{1'b0}}};
`else
  assign addr_out_s = addr_r;
`endif

  // All outputs are decoded straight from registers, no input paths.
  assign bus.read_o    = rd_s;
  assign bus.write_o   = wr_s;
  assign bus.resp_o    = (state_r == S_DONE);
  assign bus.line_o    = buf_r;
  assign bus.address_o = (rd_s || wr_s) ? addr_out_s : '0;
  // the counter only advances on resp_i, so the current beat holds across gaps
  assign bus.burst_o   = wr_s ? buf_r[cnt_r*BURST_W +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed self-checking bench for cacheline_adaptor.
// Inputs change 1 time unit after posedge; outputs are checked in the same
// window, i.e. they show the state entered at that posedge ("cycle n").
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  cacheline_adaptor_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) bus ();

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.line_i    = '0;
    bus.address_i = 32'h0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = 64'h0;
    bus.resp_i    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle_inputs();
    tick(); tick(); tick();
    vectors++; if (bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL reset_resp: got %b expected 0", bus.resp_o); end
    vectors++; if (bus.read_o !== 1'b0) begin miscompares++; $display("FAIL reset_read: got %b expected 0", bus.read_o); end
    vectors++; if (bus.write_o !== 1'b0) begin miscompares++; $display("FAIL reset_write: got %b expected 0", bus.write_o); end
    vectors++; if (bus.burst_o !== 64'h0) begin miscompares++; $display("FAIL reset_burst: got %h expected 0", bus.burst_o); end
    vectors++; if (bus.address_o !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", bus.address_o); end
    vectors++; if (bus.line_o !== 256'h0) begin miscompares++; $display("FAIL reset_line: got %h expected 0", bus.line_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_contig;
    logic [63:0] beats [4];
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    bus.address_i = 32'h0000_1040;
    bus.read_i    = 1'b1;
    vectors++; if (bus.read_o !== 1'b0) begin miscompares++; $display("FAIL rd_c0_read: got %b expected 0", bus.read_o); end
    vectors++; if (bus.address_o !== 32'h0) begin miscompares++; $display("FAIL rd_c0_addr: got %h expected 0", bus.address_o); end
    tick();
    vectors++; if (bus.read_o !== 1'b1) begin miscompares++; $display("FAIL rd_c1_read: got %b expected 1", bus.read_o); end
    vectors++; if (bus.address_o !== 32'h0000_1040) begin miscompares++; $display("FAIL rd_c1_addr: got %h expected 00001040", bus.address_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.resp_i  = 1'b1;
      bus.burst_i = beats[k];
      vectors++; if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL rd_beat%0d: got read_o=%b resp_o=%b expected 1/0", k, bus.read_o, bus.resp_o); end
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
    bus.read_i  = 1'b0;
    vectors++; if (bus.resp_o !== 1'b1) begin miscompares++; $display("FAIL rd_c6_resp: got %b expected 1", bus.resp_o); end
    vectors++; if (bus.read_o !== 1'b0) begin miscompares++; $display("FAIL rd_c6_read: got %b expected 0", bus.read_o); end
    vectors++; if (bus.line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin miscompares++; $display("FAIL rd_c6_line: got %h expected %h", bus.line_o, {beats[3], beats[2], beats[1], beats[0]}); end
    tick();
    vectors++; if (bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL rd_c7_resp: got %b expected 0", bus.resp_o); end
    vectors++; if (bus.line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin miscompares++; $display("FAIL rd_c7_line_hold: got %h expected %h", bus.line_o, {beats[3], beats[2], beats[1], beats[0]}); end
  endtask

  task automatic test_read_gaps;
    logic [63:0] beats [4];
    logic        pat [7];
    int          n;
    beats[0] = 64'hA0A0_0000_0000_00A0;
    beats[1] = 64'hA1A1_1111_0000_00A1;
    beats[2] = 64'hA2A2_2222_0000_00A2;
    beats[3] = 64'hA3A3_3333_0000_00A3;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
    n = 0;
    bus.address_i = 32'h0000_2000;
    bus.read_i    = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++; if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL gap_step%0d: got read_o=%b resp_o=%b expected 1/0", i, bus.read_o, bus.resp_o); end
      // requester abandons the request mid-burst; the burst must still finish
      if (i == 1) bus.read_i = 1'b0;
      bus.resp_i = pat[i];
      if (pat[i]) begin
        bus.burst_i = beats[n];
        n++;
      end else begin
        bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
    vectors++; if (bus.resp_o !== 1'b1) begin miscompares++; $display("FAIL gap_resp: got %b expected 1", bus.resp_o); end
    vectors++; if (bus.line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin miscompares++; $display("FAIL gap_line: got %h expected %h", bus.line_o, {beats[3], beats[2], beats[1], beats[0]}); end
    tick();
    vectors++; if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin miscompares++; $display("FAIL gap_idle: got resp_o=%b read_o=%b expected 0/0", bus.resp_o, bus.read_o); end
  endtask

  task automatic test_write;
    logic [63:0] w [4];
    logic        pat [5];
    int          idx [5];
    w[0] = 64'hDEAD_BEEF_0000_0000;
    w[1] = 64'hDEAD_BEEF_1111_1111;
    w[2] = 64'hDEAD_BEEF_2222_2222;
    w[3] = 64'hDEAD_BEEF_3333_3333;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1;
    idx[0] = 0; idx[1] = 1; idx[2] = 1; idx[3] = 2; idx[4] = 3;
    bus.line_i    = {w[3], w[2], w[1], w[0]};
    bus.address_i = 32'h0000_3000;
    bus.write_i   = 1'b1;
    vectors++; if (bus.write_o !== 1'b0) begin miscompares++; $display("FAIL wr_c0_write: got %b expected 0", bus.write_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (bus.write_o !== 1'b1 || bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL wr_step%0d_ctl: got write_o=%b resp_o=%b expected 1/0", i, bus.write_o, bus.resp_o); end
      vectors++; if (bus.burst_o !== w[idx[i]]) begin miscompares++; $display("FAIL wr_step%0d_data: got %h expected %h", i, bus.burst_o, w[idx[i]]); end
      vectors++; if (bus.address_o !== 32'h0000_3000) begin miscompares++; $display("FAIL wr_step%0d_addr: got %h expected 00003000", i, bus.address_o); end
      bus.resp_i = pat[i];
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.write_i = 1'b0;
    bus.line_i  = '0;
    vectors++; if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin miscompares++; $display("FAIL wr_done: got resp_o=%b write_o=%b expected 1/0", bus.resp_o, bus.write_o); end
    vectors++; if (bus.burst_o !== 64'h0) begin miscompares++; $display("FAIL wr_done_burst: got %h expected 0", bus.burst_o); end
    vectors++; if (bus.line_o !== {w[3], w[2], w[1], w[0]}) begin miscompares++; $display("FAIL wr_line_buf: got %h expected %h", bus.line_o, {w[3], w[2], w[1], w[0]}); end
    tick();
    vectors++; if (bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL wr_after: got %b expected 0", bus.resp_o); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] w [4];
    logic [63:0] r [4];
    for (int k = 0; k < 4; k++) begin
      w[k] = 64'h5050_0000_0000_0000 + 64'(k);
      r[k] = 64'h6060_0000_0000_0000 + 64'(k);
    end
    bus.line_i    = {w[3], w[2], w[1], w[0]};
    bus.address_i = 32'h0000_0080;
    bus.write_i   = 1'b1;
    bus.read_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0) begin miscompares++; $display("FAIL b2b_wr%0d_ctl: got write_o=%b read_o=%b expected 1/0", k, bus.write_o, bus.read_o); end
      vectors++; if (bus.burst_o !== w[k]) begin miscompares++; $display("FAIL b2b_wr%0d_data: got %h expected %h", k, bus.burst_o, w[k]); end
      bus.resp_i = 1'b1;
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.write_i = 1'b0;
    vectors++; if (bus.resp_o !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_resp: got %b expected 1", bus.resp_o); end
    tick();
    vectors++; if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got read_o=%b resp_o=%b expected 0/0", bus.read_o, bus.resp_o); end
    tick();
    vectors++; if (bus.read_o !== 1'b1 || bus.address_o !== 32'h0000_0080) begin miscompares++; $display("FAIL b2b_rd_start: got read_o=%b addr=%h expected 1/00000080", bus.read_o, bus.address_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.resp_i  = 1'b1;
      bus.burst_i = r[k];
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
    bus.read_i  = 1'b0;
    vectors++; if (bus.resp_o !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_resp: got %b expected 1", bus.resp_o); end
    vectors++; if (bus.line_o !== {r[3], r[2], r[1], r[0]}) begin miscompares++; $display("FAIL b2b_rd_line: got %h expected %h", bus.line_o, {r[3], r[2], r[1], r[0]}); end
    tick();
  endtask

  task automatic test_reset_midburst;
    logic [63:0] c [4];
    c[0] = 64'hC0C0_C0C0_0000_0001;
    c[1] = 64'hC1C1_C1C1_0000_0002;
    c[2] = 64'hC2C2_C2C2_0000_0003;
    c[3] = 64'hC3C3_C3C3_0000_0004;
    bus.address_i = 32'h0000_4000;
    bus.read_i    = 1'b1;
    tick();
    tick();
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hEEEE_EEEE_EEEE_0000;
    tick();
    bus.burst_i = 64'hEEEE_EEEE_EEEE_0001;
    tick();
    rst         = 1'b0;
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
    bus.read_i  = 1'b0;
    tick();
    rst = 1'b1;
    vectors++; if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctl: got read_o=%b write_o=%b resp_o=%b expected 0/0/0", bus.read_o, bus.write_o, bus.resp_o); end
    vectors++; if (bus.address_o !== 32'h0 || bus.burst_o !== 64'h0) begin miscompares++; $display("FAIL rstmid_bus: got addr=%h burst=%h expected 0/0", bus.address_o, bus.burst_o); end
    vectors++; if (bus.line_o !== 256'h0) begin miscompares++; $display("FAIL rstmid_line: got %h expected 0", bus.line_o); end
    bus.address_i = 32'h0000_5000;
    bus.read_i    = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.resp_i  = 1'b1;
      bus.burst_i = c[k];
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
    bus.read_i  = 1'b0;
    vectors++; if (bus.resp_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_resp: got %b expected 1", bus.resp_o); end
    vectors++; if (bus.line_o !== {c[3], c[2], c[1], c[0]}) begin miscompares++; $display("FAIL rstmid_line_new: got %h expected %h", bus.line_o, {c[3], c[2], c[1], c[0]}); end
    tick();
  endtask

  task automatic test_align;
    logic [31:0] exp_addr;
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    exp_addr = 32'h0000_1040;
`else
    exp_addr = 32'h0000_105C;
`endif
    bus.address_i = 32'h0000_105C;
    bus.read_i    = 1'b1;
    tick();
    vectors++; if (bus.address_o !== exp_addr) begin miscompares++; $display("FAIL align_addr: got %h expected %h", bus.address_o, exp_addr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h7700_0000_0000_0000 + 64'(k);
    end
    tick();
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'h0;
    bus.read_i  = 1'b0;
    vectors++; if (bus.resp_o !== 1'b1 || bus.address_o !== 32'h0) begin miscompares++; $display("FAIL align_done: got resp_o=%b addr=%h expected 1/0", bus.resp_o, bus.address_o); end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    idle_inputs();
    test_reset();
    test_read_contig();
    test_read_gaps();
    test_write();
    test_back_to_back();
    test_reset_midburst();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
